// File: rtl/freq_phase_sched.sv
// -----------------------------------------------------------------------------
// freq_phase_sched
//
// Converts per-receiver frequency words (Hz) into 32-bit NCO/CORDIC phase
// increments, phase = freq * 2^32 / 122.88 MHz, by time-sharing a single
// serial shift-add multiplier.  Channels are recomputed on demand (after a
// write) in round-robin order starting after the last serviced channel.
//
// Optional feature (compile-time macro):
//   FREQ_PHASE_ROUND_EN  defined   -> round-half-up of acc[56:25] using acc[24]
//                        undefined -> truncation to acc[56:25]
//
// Parameters:
//   NUM_RX  number of receiver channels (1..8)
//   M2      constant multiplicand, 2^57 / 122.88e6
//
// Ports:
//   clock       system clock (122.88 MHz)
//   reset_n     asynchronous active-low reset
//   freq_wr     one-cycle write strobe
//   freq_addr   target channel; addresses >= NUM_RX are ignored
//   freq_data   frequency in Hz (unsigned)
//   phase_word  per-channel phase words, channel k at [32k+31:32k]
//   phase_upd   one-cycle pulse per channel when its phase word is rewritten
//   busy        high whenever the scheduler is not idle
// -----------------------------------------------------------------------------
module freq_phase_sched #(
  parameter int          NUM_RX = 4,
  parameter logic [31:0] M2     = 32'd1172812403
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 freq_wr,
  input  logic [2:0]           freq_addr,
  input  logic [31:0]          freq_data,
  output logic [NUM_RX*32-1:0] phase_word,
  output logic [NUM_RX-1:0]    phase_upd,
  output logic                 busy
);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_MUL, ST_STORE} state_t;

  state_t            r_state;
  state_t            w_state_next;

  logic [31:0]       r_freq  [NUM_RX];
  logic [31:0]       r_phase [NUM_RX];
  logic [NUM_RX-1:0] r_pending;
  logic [NUM_RX-1:0] r_phase_upd;
  logic [NUM_RX-1:0] w_set;
  logic [NUM_RX-1:0] w_clr;
  logic [2:0]        r_ch;
  logic [2:0]        r_last_ch;
  logic [2:0]        w_grant_ch;
  logic              w_grant_any;
  logic              w_grant;
  logic [3:0]        w_idx;
  logic [7:0]        w_pend8;
  logic [31:0]       r_mcand;
  logic [31:0]       w_mcand_sel;
  logic [31:0]       w_result;
  logic [63:0]       r_acc;
  logic [4:0]        r_cnt;
  logic              w_unused;

  // Per-channel strobes and output mapping.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_RX; gi++) begin : g_ch
      assign w_set[gi]                 = freq_wr && (freq_addr == 3'(gi));
      assign w_clr[gi]                 = w_grant && (w_grant_ch == 3'(gi));
      assign phase_word[gi*32 +: 32]   = r_phase[gi];
    end
  endgenerate

  assign phase_upd = r_phase_upd;
  assign busy      = (r_state != ST_IDLE);
  assign w_pend8   = 8'(r_pending);

  // Round-robin search: walk from farthest to nearest so the channel closest
  // after r_last_ch is the one left standing.
  always_comb begin
    w_grant_any = 1'b0;
    w_grant_ch  = 3'd0;
    w_idx       = 4'd0;
    for (int i = NUM_RX; i >= 1; i--) begin
      w_idx = {1'b0, r_last_ch} + 4'(i);
      if (w_idx >= 4'(NUM_RX)) w_idx = w_idx - 4'(NUM_RX);
      if (w_pend8[w_idx[2:0]]) begin
        w_grant_any = 1'b1;
        w_grant_ch  = w_idx[2:0];
      end
    end
  end

  always_comb begin
    w_mcand_sel = 32'd0;
    for (int i = 0; i < NUM_RX; i++) begin
      if (r_ch == 3'(i)) w_mcand_sel = r_freq[i];
    end
  end

`ifdef FREQ_PHASE_ROUND_EN
  assign w_result = r_acc[56:25] + {31'd0, r_acc[24]};
`else
  assign w_result = r_acc[56:25];
`endif
  // Bits above 56 alias out-of-band frequencies; bits below 25 are fraction.
  assign w_unused = ^{r_acc[63:57], r_acc[24:0]};

  // Next-state logic.  The IDLE cycle that carries the phase_upd pulse is a
  // turnaround cycle with no grant, giving a fixed 36-cycle service period.
  always_comb begin
    w_state_next = r_state;
    w_grant      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_grant_any && (r_phase_upd == '0)) begin
          w_grant      = 1'b1;
          w_state_next = ST_LOAD;
        end
      end
      ST_LOAD:  w_state_next = ST_MUL;
      ST_MUL:   if (r_cnt == 5'd31) w_state_next = ST_STORE;
      ST_STORE: w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_next;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_pending   <= '0;
      r_phase_upd <= '0;
      r_ch        <= 3'd0;
      r_last_ch   <= 3'(NUM_RX - 1);
      r_mcand     <= 32'd0;
      r_acc       <= 64'd0;
      r_cnt       <= 5'd0;
      for (int i = 0; i < NUM_RX; i++) begin
        r_freq[i]  <= 32'd0;
        r_phase[i] <= 32'd0;
      end
    end else begin
      // A write landing on the same cycle as the grant clear keeps pending set.
      r_pending   <= (r_pending & ~w_clr) | w_set;
      r_phase_upd <= '0;
      for (int i = 0; i < NUM_RX; i++) begin
        if (w_set[i]) r_freq[i] <= freq_data;
      end
      if (w_grant) r_ch <= w_grant_ch;
      case (r_state)
        ST_LOAD: begin
          r_mcand <= w_mcand_sel;
          r_acc   <= 64'd0;
          r_cnt   <= 5'd0;
        end
        ST_MUL: begin
          if (r_mcand[r_cnt]) r_acc <= r_acc + ({32'd0, M2} << r_cnt);
          r_cnt <= r_cnt + 5'd1;
        end
        ST_STORE: begin
          for (int i = 0; i < NUM_RX; i++) begin
            if (r_ch == 3'(i)) begin
              r_phase[i]     <= w_result;
              r_phase_upd[i] <= 1'b1;
            end
          end
          r_last_ch <= r_ch;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_freq_phase_sched.sv
// -----------------------------------------------------------------------------
// tb_freq_phase_sched
//
// Directed testbench for freq_phase_sched (NUM_RX = 4).  Expected phase words
// come from hand-computed constants or from a direct 64-bit product model,
// phase = (freq * M2)[56:25] (+ bit 24 when FREQ_PHASE_ROUND_EN is defined).
// -----------------------------------------------------------------------------
module tb_freq_phase_sched;

  localparam int          NUM_RX = 4;
  localparam logic [31:0] M2     = 32'd1172812403;

  logic                 clock;
  logic                 reset_n;
  logic                 freq_wr;
  logic [2:0]           freq_addr;
  logic [31:0]          freq_data;
  logic [NUM_RX*32-1:0] phase_word;
  logic [NUM_RX-1:0]    phase_upd;
  logic                 busy;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  freq_phase_sched #(.NUM_RX(NUM_RX), .M2(M2)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .freq_wr    (freq_wr),
    .freq_addr  (freq_addr),
    .freq_data  (freq_data),
    .phase_word (phase_word),
    .phase_upd  (phase_upd),
    .busy       (busy)
  );

  initial clock = 1'b0;
  always #4 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  function automatic logic [31:0] model(input logic [31:0] f);
    logic [63:0] p;
    p = {32'd0, f} * {32'd0, M2};
`ifdef FREQ_PHASE_ROUND_EN
    return p[56:25] + {31'd0, p[24]};
`else
    return p[56:25];
`endif
  endfunction

  function automatic logic [31:0] word_of(input int ch);
    return phase_word[ch*32 +: 32];
  endfunction

  // Write strobe lands on one rising edge; e0 is the cycle count of that edge.
  task automatic do_write(input logic [2:0] addr, input logic [31:0] data, output int e0);
    @(negedge clock);
    freq_wr   = 1'b1;
    freq_addr = addr;
    freq_data = data;
    @(posedge clock);
    #1;
    e0        = cyc;
    freq_wr   = 1'b0;
  endtask

  // Waits (bounded) for the next phase_upd pulse; at = -1 on timeout.
  task automatic wait_upd(output logic [NUM_RX-1:0] upd, output int at);
    upd = '0;
    at  = -1;
    for (int k = 0; k < 300; k++) begin
      @(negedge clock);
      if (phase_upd != '0) begin
        upd = phase_upd;
        at  = cyc;
        break;
      end
    end
  endtask

  // Counts pulses over n idle cycles.
  task automatic count_pulses(input int n, output int pulses);
    pulses = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clock);
      if (phase_upd != '0) pulses++;
    end
  endtask

  logic [NUM_RX-1:0]    upd;
  logic [NUM_RX*32-1:0] snap;
  int                   e0, e0a, at, pulses, busy_seen;
  logic [2:0]           ord_ch  [4];
  logic [31:0]          ord_val [4];

  initial begin
    reset_n   = 1'b0;
    freq_wr   = 1'b0;
    freq_addr = 3'd0;
    freq_data = 32'd0;
    repeat (3) @(negedge clock);
    #1;
    check("reset_phase_word", 128'(phase_word), 128'd0);
    check("reset_phase_upd", 128'(phase_upd), 128'd0);
    check("reset_busy", 128'(busy), 128'd0);
    @(negedge clock);
    reset_n = 1'b1;

    // Idle for 100 cycles: nothing happens.
    pulses    = 0;
    busy_seen = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clock);
      if (phase_upd != '0) pulses++;
      if (busy) busy_seen++;
    end
    check("idle_pulses", 128'(pulses), 128'd0);
    check("idle_busy_cycles", 128'(busy_seen), 128'd0);
    check("idle_phase_word", 128'(phase_word), 128'd0);

    // ch0 = 10 MHz, latency and busy.
    do_write(3'd0, 32'd10_000_000, e0);
    repeat (2) @(negedge clock);
    check("ch0_busy_after_grant", 128'(busy), 128'd1);
    wait_upd(upd, at);
    check("ch0_latency", 128'(at - e0), 128'd35);
    check("ch0_upd_mask", 128'(upd), 128'b0001);
    check("ch0_word", 128'(word_of(0)), 128'h14D55555);
    @(negedge clock);
    check("ch0_upd_one_cycle", 128'(phase_upd), 128'd0);

    // ch1 = 1 Hz: rounding boundary.
    do_write(3'd1, 32'd1, e0);
    wait_upd(upd, at);
    check("ch1_latency", 128'(at - e0), 128'd35);
    check("ch1_upd_mask", 128'(upd), 128'b0010);
`ifdef FREQ_PHASE_ROUND_EN
    check("ch1_word", 128'(word_of(1)), 128'd35);
`else
    check("ch1_word", 128'(word_of(1)), 128'd34);
`endif
    check("ch0_word_held", 128'(word_of(0)), 128'h14D55555);

    // Round-robin: ch3 in service (last_ch becomes 3), then ch3, ch0, ch2
    // written on consecutive cycles -> served ch0, ch2, ch3.
    do_write(3'd3, 32'd20_000_000, e0a);
    repeat (5) @(negedge clock);
    do_write(3'd3, 32'd30_000_000, e0);
    do_write(3'd0, 32'd50_000_000, e0);
    do_write(3'd2, 32'd61_440_000, e0);
    ord_ch[0] = 3'd3; ord_val[0] = model(32'd20_000_000);
    ord_ch[1] = 3'd0; ord_val[1] = model(32'd50_000_000);
    ord_ch[2] = 3'd2; ord_val[2] = model(32'd61_440_000);
    ord_ch[3] = 3'd3; ord_val[3] = model(32'd30_000_000);
    for (int n = 0; n < 4; n++) begin
      wait_upd(upd, at);
      check($sformatf("rr%0d_time", n), 128'(at - e0a), 128'(35 + 36 * n));
      check($sformatf("rr%0d_mask", n), 128'(upd), 128'(4'b0001 << ord_ch[n]));
      check($sformatf("rr%0d_word", n), 128'(word_of(int'(ord_ch[n]))), 128'(ord_val[n]));
    end
    check("ch1_word_undisturbed", 128'(word_of(1)), 128'(model(32'd1)));

    // Rewrite ch2 during MUL cycle 10: old value finishes, new one follows.
    do_write(3'd2, 32'd7_000_000, e0);
    repeat (12) @(negedge clock);
    do_write(3'd2, 32'd14_200_000, e0a);
    check("rewrite_in_mul_cycle", 128'(e0a - e0), 128'd13);
    wait_upd(upd, at);
    check("rewrite1_time", 128'(at - e0), 128'd35);
    check("rewrite1_mask", 128'(upd), 128'b0100);
    check("rewrite1_word", 128'(word_of(2)), 128'h0E955555);
    wait_upd(upd, at);
    check("rewrite2_time", 128'(at - e0), 128'd71);
    check("rewrite2_mask", 128'(upd), 128'b0100);
    check("rewrite2_word", 128'(word_of(2)), 128'(model(32'd14_200_000)));

    // Out-of-range address: ignored.
    snap = phase_word;
    do_write(3'd6, 32'd12_345_678, e0);
    repeat (2) @(negedge clock);
    check("badaddr_busy", 128'(busy), 128'd0);
    count_pulses(50, pulses);
    check("badaddr_pulses", 128'(pulses), 128'd0);
    check("badaddr_words", 128'(phase_word), 128'(snap));

    // Reset mid-MUL: immediate clear, no later pulse.
    do_write(3'd1, 32'd5000, e0);
    repeat (15) @(negedge clock);
    check("mid_mul_busy", 128'(busy), 128'd1);
    reset_n = 1'b0;
    #1;
    check("abort_phase_word", 128'(phase_word), 128'd0);
    check("abort_phase_upd", 128'(phase_upd), 128'd0);
    check("abort_busy", 128'(busy), 128'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    count_pulses(60, pulses);
    check("abort_no_pulse", 128'(pulses), 128'd0);
    check("abort_words_zero", 128'(phase_word), 128'd0);
    check("abort_idle", 128'(busy), 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
